// File: rtl/bcd_to_ex3_seq.sv
// Sequential BCD-to-Excess-3 encoder: captures a packed BCD word, converts one
// digit per clock (LSD first), and holds the packed Excess-3 result until consumed.
module bcd_to_ex3_seq #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   ex3_out,
    output logic                  err,
    output logic                  busy,
    output logic [1:0]            dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; in_ready is high only in IDLE, out_valid only in DONE, so an
    // accept and an output handshake can never share an edge.

    localparam int W     = 4 * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [W-1:0]     word_q,  word_d;
    logic [W-1:0]     ex3_q,   ex3_d;
    logic             err_q,   err_d;
    logic [IDX_W-1:0] idx_q,   idx_d;
    logic [3:0]       cur_digit;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            word_q  <= '0;
            ex3_q   <= '0;
            err_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            ex3_q   <= ex3_d;
            err_q   <= err_d;
            idx_q   <= idx_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)          state_d = CONV;
            CONV:    if (idx_q == LAST_IDX) state_d = DONE;
            DONE:    if (out_ready)         state_d = IDLE;
            default:                        state_d = IDLE;
        endcase
    end

    // Digit currently being converted
    always_comb begin
        cur_digit = 4'd0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                cur_digit = word_q[4*k +: 4];
            end
        end
    end

    // Datapath next values
    always_comb begin
        word_d = word_q;
        ex3_d  = ex3_q;
        err_d  = err_q;
        idx_d  = idx_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    word_d = bcd_in;
                    ex3_d  = '0;
                    err_d  = 1'b0;
                    idx_d  = '0;
                end
            end
            CONV: begin
                for (int k = 0; k < DIGITS; k++) begin
                    if (idx_q == IDX_W'(k)) begin
                        // Non-BCD digits become 0000, which is not a legal Excess-3 code
                        ex3_d[4*k +: 4] = (cur_digit <= 4'd9) ? (cur_digit + 4'd3) : 4'd0;
                    end
                end
                if (cur_digit > 4'd9) begin
                    err_d = 1'b1;
                end
                idx_d = idx_q + 1'b1;
            end
            default: ;
        endcase
    end

    // Outputs
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q == CONV) || (state_q == DONE);
        ex3_out   = ex3_q;
        err       = err_q;
        dbg_state = state_q;
    end

endmodule
